// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared state encoding and default constants for the LFSR generator
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lfsr_state_e;

  localparam logic [7:0] LFSR_TAPS_8 = 8'h97;
  localparam logic [7:0] LFSR_SEED_8 = 8'h01;

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational Fibonacci LFSR step
module lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h97)
)(
  input  logic [WIDTH-1:0] lfsr_i,
  output logic [WIDTH-1:0] lfsr_next_o
);

  logic fb;

  // Feedback is the parity of the tapped bits, shifted in at the LSB
  always_comb begin
    fb          = ^(lfsr_i & TAPS);
    lfsr_next_o = {lfsr_i[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/lfsr_multistep_gen.sv
// rtl/lfsr_multistep_gen.sv - request-driven multi-step LFSR generator with reseed and re-arm
module lfsr_multistep_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_TAPS_8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(LFSR_SEED_8),
  parameter int               STEP_W       = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  generated_number
);

  lfsr_state_e       state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  lfsr_next;
  logic [WIDTH-1:0]  gen_q, gen_d;
  logic [WIDTH-1:0]  seed_fixed;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .lfsr_i      (lfsr_q),
    .lfsr_next_o (lfsr_next)
  );

  // A zero seed would lock the register at zero, so it is replaced by the default
  always_comb begin
    seed_fixed = (seed == '0) ? DEFAULT_SEED : seed;
  end

  // Next-state logic: accept in IDLE, shift cnt times in RUN, publish in DONE
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    gen_d   = gen_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    armed_d = armed_q;

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d = seed_fixed;
        end else if (req && armed_q) begin
          cnt_d   = (n_steps == '0) ? STEP_W'(1) : n_steps;
          busy_d  = 1'b1;
          armed_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q - STEP_W'(1);
        if (cnt_q == STEP_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        gen_d   = lfsr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A low request re-arms from any state so the next assertion yields one result
    if (!req) begin
      armed_d = 1'b1;
    end
  end

  // State registers; reset reloads the seed and discards any run in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= seed_fixed;
      gen_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gen_q   <= gen_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign generated_number = gen_q;

endmodule

// File: tb/tb_lfsr_multistep_gen.sv
// tb/tb_lfsr_multistep_gen.sv - directed self-checking bench for lfsr_multistep_gen
module tb_lfsr_multistep_gen;

  logic       clk = 1'b0;
  logic       rst, req, seed_load;
  logic [3:0] n_steps;
  logic [7:0] seed;
  logic       busy, done;
  logic [7:0] gen;

  logic        rst16, req16, seed_load16;
  logic [3:0]  n16;
  logic [15:0] seed16;
  logic        busy16, done16;
  logic [15:0] gen16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_multistep_gen dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .n_steps          (n_steps),
    .seed_load        (seed_load),
    .seed             (seed),
    .busy             (busy),
    .done             (done),
    .generated_number (gen)
  );

  lfsr_multistep_gen #(
    .WIDTH        (16),
    .TAPS         (16'hB400),
    .DEFAULT_SEED (16'h0001),
    .STEP_W       (4)
  ) dut16 (
    .clk              (clk),
    .rst              (rst16),
    .req              (req16),
    .n_steps          (n16),
    .seed_load        (seed_load16),
    .seed             (seed16),
    .busy             (busy16),
    .done             (done16),
    .generated_number (gen16)
  );

  typedef struct {
    logic [3:0] n;
    logic [7:0] exp_gen;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst = 1'b0; req = 1'b0; seed_load = 1'b0; seed = s; n_steps = 4'd1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Raises req and waits (bounded) for done; lat counts edges from acceptance to done
  task automatic run8(input logic [3:0] n, output int lat, output int bcnt, output logic [7:0] got);
    req = 1'b1; n_steps = n;
    @(negedge clk);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    got = gen;
  endtask

  initial begin
    vec_t       vecs[5];
    int         lat, bcnt, cnt;
    logic [7:0] got;
    logic [15:0] m;

    vecs[0] = '{4'd1, 8'h03, 2};
    vecs[1] = '{4'd2, 8'h0C, 3};
    vecs[2] = '{4'd3, 8'h64, 4};
    vecs[3] = '{4'd0, 8'hC9, 2};
    vecs[4] = '{4'd4, 8'h95, 5};

    rst16 = 1'b0; req16 = 1'b0; seed_load16 = 1'b0; n16 = 4'd1; seed16 = 16'h0001;

    // Reset with zero seed: outputs cleared, internal state is DEFAULT_SEED
    do_reset(8'h00);
    rst16 = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_gen", {24'd0, gen}, 32'h00);
    run8(4'd1, lat, bcnt, got);
    chk("zero_seed_gen", {24'd0, got}, 32'h03);
    chk("zero_seed_lat", lat, 2);
    req = 1'b0;
    @(negedge clk);
    chk("zero_seed_done_pulse", {31'd0, done}, 32'd0);

    // Table of chained runs from seed 0x01
    do_reset(8'h01);
    for (int i = 0; i < 5; i++) begin
      run8(vecs[i].n, lat, bcnt, got);
      chk($sformatf("vec%0d_gen", i), {24'd0, got}, {24'd0, vecs[i].exp_gen});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_busy", i), bcnt, vecs[i].exp_lat);
      req = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_done_low", i), {31'd0, done}, 32'd0);
    end

    // Holding req high yields exactly one result
    do_reset(8'h01);
    req = 1'b1; n_steps = 4'd2;
    cnt = 0; got = 8'h00;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) begin cnt++; got = gen; end
    end
    chk("hold_done_count", cnt, 1);
    chk("hold_gen", {24'd0, got}, 32'h06);
    chk("hold_busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    @(negedge clk);

    // Drop req mid-run, re-raise during DONE: next run starts the following cycle
    req = 1'b1; n_steps = 4'd3;
    @(negedge clk);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    req = 1'b0;
    repeat (3) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    chk("drop_done", {31'd0, done}, 32'd1);
    chk("drop_gen", {24'd0, gen}, 32'h32);
    @(negedge clk);
    chk("rerun_busy", {31'd0, busy}, 32'd1);
    chk("rerun_done_low", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 40) begin @(negedge clk); lat++; end
    chk("rerun_gen", {24'd0, gen}, 32'h92);
    req = 1'b0;
    @(negedge clk);

    // seed_load has priority over req in the same cycle
    seed_load = 1'b1; seed = 8'h80; req = 1'b1; n_steps = 4'd1;
    @(negedge clk);
    chk("reseed_no_run", {31'd0, busy}, 32'd0);
    seed_load = 1'b0;
    run8(4'd1, lat, bcnt, got);
    chk("reseed_gen", {24'd0, got}, 32'h01);
    chk("reseed_lat", lat, 2);
    req = 1'b0;
    @(negedge clk);
    seed_load = 1'b1; seed = 8'h00;
    @(negedge clk);
    seed_load = 1'b0;
    run8(4'd1, lat, bcnt, got);
    chk("reseed_zero_gen", {24'd0, got}, 32'h03);
    req = 1'b0;
    @(negedge clk);

    // Reset mid-run: nothing published, next run restarts from seed
    seed = 8'h80;
    req = 1'b1; n_steps = 4'd15;
    repeat (5) @(negedge clk);
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_gen", {24'd0, gen}, 32'h00);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run8(4'd1, lat, bcnt, got);
    chk("midrst_restart_gen", {24'd0, got}, 32'h01);
    req = 1'b0;
    @(negedge clk);

    // 16-bit instance: 100 single steps against a reference model
    m = 16'h0001;
    for (int i = 0; i < 100; i++) begin
      m = {m[14:0], ^(m & 16'hB400)};
      req16 = 1'b1; n16 = 4'd1;
      @(negedge clk);
      lat = 0;
      while (!done16 && lat < 10) begin @(negedge clk); lat++; end
      chk($sformatf("w16_step%0d", i), {16'd0, gen16}, {16'd0, m});
      req16 = 1'b0;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_multistep_gen.md
Name: lfsr_multistep_gen

Overview:
- Parametrised successor to the 8-bit single-step LFSR generator.
- Holds a WIDTH-bit Fibonacci LFSR with a configurable tap mask. On each accepted request it advances by a run-time selectable number of steps (1..2^STEP_W-1) and publishes the result with a one-cycle done pulse.
- Supports run-time reseeding, zero-seed lock-up protection, and request re-arm (one result per request assertion).
- Sits between test-pattern/stimulus consumers and the lab top level, replacing the fixed 8-bit, 1-step generator.

Parameters:
- WIDTH, 8, LFSR register width (>= 3).
- TAPS, 8'h97, feedback mask of WIDTH bits; bit i set means state bit i feeds the XOR. Bit WIDTH-1 must be set.
- DEFAULT_SEED, 8'h01, nonzero value substituted whenever a zero seed is loaded.
- STEP_W, 4, width of the n_steps input.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-low reset; rst==0 at a clk edge resets the block.
- req  input  1  level request; one result per assertion.
- n_steps  input  STEP_W  steps to advance; sampled on acceptance; 0 is treated as 1.
- seed_load  input  1  load seed into the LFSR (IDLE only).
- seed  input  WIDTH  seed value for reset and seed_load.
- busy  output  1  high from acceptance until the result is published.
- done  output  1  one-cycle pulse when generated_number updates.
- generated_number  output  WIDTH  last published LFSR value.

Behaviour:
- Step function: fb = XOR-reduce(lfsr & TAPS); lfsr_next = {lfsr[WIDTH-2:0], fb}. With WIDTH=8 and TAPS=8'h97 this is bit-identical to the existing generator.
- Reset (rst==0 at an edge):
  - lfsr <= (seed==0 ? DEFAULT_SEED : seed).
  - state <= IDLE, busy <= 0, done <= 0, generated_number <= 0, armed <= 1, cnt <= 0.
  - Reset overrides everything, including mid-RUN; no partial result is published.
- States:
  - IDLE:
    - If seed_load: load lfsr (zero maps to DEFAULT_SEED); no request accepted that cycle. seed_load has priority over req.
    - Else if req && armed: cnt <= max(n_steps,1), busy <= 1, armed <= 0, go to RUN. No shift at the acceptance edge.
  - RUN: each edge, lfsr <= lfsr_next and cnt <= cnt-1. When cnt==1 at the edge, go to DONE.
  - DONE: generated_number <= lfsr, done <= 1, busy <= 0, go to IDLE.
  - done is cleared at the following edge (single-cycle pulse).
- Latency: accept at edge E0, shifts at E1..En, output and done valid after E(n+1), done low again after E(n+2).
- Re-arm:
  - armed <= 1 at any edge where req==0, in any state.
  - Dropping req mid-RUN does not abort; the run completes, and the next assertion is accepted once back in IDLE.
  - Holding req high across completion yields no second run.
- seed_load in RUN or DONE is ignored (not queued).
- n_steps and seed changes after acceptance have no effect on the current run.
- generated_number holds its value between runs.
- Zero state is unreachable from a nonzero seed because TAPS[WIDTH-1]=1. No other lock-up handling is required.

Decomposition:
- Package lfsr_pkg:
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default 8-bit tap constant 8'h97.
  - Default seed constant 8'h01.
- Sub-module lfsr_step (parameters WIDTH, TAPS): purely combinational, lfsr -> lfsr_next. It is reused by future multi-channel variants and can be tested standalone.

Test Plan:
- Reset check: rst=0 with seed=8'h00 for 2 cycles, then rst=1 -> busy=0, done=0, generated_number=8'h00. Then req=1, n_steps=1 -> generated_number=8'h03 (internal state initialised to DEFAULT_SEED 8'h01), done pulses once.
- Basic run: reset with seed=8'h01; req=1, n_steps=1 -> generated_number=8'h03, busy high exactly 2 cycles. Release req, req=1, n_steps=2 -> 8'h0C (8'h03->8'h06->8'h0C).
- Latency check: seed 8'h01, n_steps=3 -> done exactly 4 edges after acceptance, generated_number=8'h0C. n_steps=0 -> behaves as 1 (8'h03).
- Re-arm: hold req high through 3 consecutive run-lengths -> exactly one done pulse. Drop req mid-RUN and re-raise it during DONE -> second run starts in the next IDLE cycle.
- Reseed priority: in IDLE assert seed_load=1, seed=8'h80, and req=1 together -> no run that cycle. Next cycle a run with n_steps=1 gives 8'h01. seed_load with seed=0 then n_steps=1 -> 8'h03.
- Reset mid-run and width: rst=0 during RUN with n_steps=15 -> done never pulses, busy=0, and the next run restarts from seed. Instantiate WIDTH=16, TAPS=16'hB400, seed 16'h0001, and compare 100 single-step results against the reference model.
